// File: rtl/qspi_flash_ctrl.sv
// qspi_flash_ctrl: host-side QSPI read controller (single/dual/quad output reads).
// Ports: start/mode/addr/len request, busy/done status, rd_data/rd_valid stream, cs_n/sck/io_* flash bus.
module qspi_flash_ctrl #(
  parameter int ADDR_W    = 24,
  parameter int LEN_W     = 8,
  parameter int CLK_DIV   = 2,
  parameter int DUMMY_CYC = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              cs_n,
  output logic              sck,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  input  logic [3:0]        io_in
);

  localparam int TX_W  = 8 + ADDR_W;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(ADDR_W + DUMMY_CYC + 9);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, DATA, HOLD
  } state_t;

  state_t            state, state_d;
  logic [DIV_W-1:0]  div_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  per_m1;
  logic [TX_W-1:0]   tx;
  logic [LEN_W-1:0]  len_left;
  logic [1:0]        mcode;
  logic [6:0]        rx;
  logic [7:0]        rx_nxt;
  logic [7:0]        cmd_sel;
  logic              tick, rise, fall;
  logic              byte_end, multi;

  // tick marks the end of each SCK half-period
  assign tick  = (state != IDLE) &&
                 (div_cnt == DIV_W'(CLK_DIV - 1));
  // no rising edge once all bytes are in: the
  // low half becomes the cs_n-low tail instead
  assign rise  = tick && !sck && (state != HOLD) &&
                 !(state == DATA && len_left == '0);
  assign fall  = tick && sck;
  assign multi = (mcode == 2'b01) || (mcode == 2'b10);

  // lane packing: higher lane is the more
  // significant bit, bytes arrive MSB first
  always_comb begin
    rx_nxt = {rx[6:0], io_in[1]};
    per_m1 = CNT_W'(7);
    unique case (1'b1)
      mcode == 2'b10: begin
        rx_nxt = {rx[3:0], io_in};
        per_m1 = CNT_W'(1);
      end
      mcode == 2'b01: begin
        rx_nxt = {rx[5:0], io_in[1:0]};
        per_m1 = CNT_W'(3);
      end
      default: ;
    endcase
  end

  always_comb begin
    cmd_sel = 8'h03;
    unique case (1'b1)
      mode == 2'b01: cmd_sel = 8'h3B;
      mode == 2'b10: cmd_sel = 8'h6B;
      default: ;
    endcase
  end

  assign byte_end = rise && (state == DATA) &&
                    (cnt == per_m1);

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:
        if (start && len != '0) state_d = CMD;
      CMD:
        if (fall && cnt == CNT_W'(8))
          state_d = ADDR;
      ADDR:
        if (fall && cnt == CNT_W'(ADDR_W))
          state_d = (multi && DUMMY_CYC != 0) ?
                    DUMMY : DATA;
      DUMMY:
        if (fall && cnt == CNT_W'(DUMMY_CYC))
          state_d = DATA;
      DATA:
        if (tick && !sck && len_left == '0)
          state_d = HOLD;
      HOLD:
        if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cs_n   = (state == IDLE) || (state == HOLD);
  assign busy   = (state != IDLE);
  assign io_oe  = (state == CMD || state == ADDR) ?
                  4'b0001 : 4'b0000;
  assign io_out = {3'b000, io_oe[0] & tx[TX_W-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      sck      <= 1'b0;
      cnt      <= '0;
      tx       <= '0;
      len_left <= '0;
      mcode    <= 2'b00;
      rx       <= '0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      if (state == IDLE) begin
        div_cnt <= '0;
        sck     <= 1'b0;
        if (start) begin
          if (len != '0) begin
            tx       <= {cmd_sel, addr};
            mcode    <= mode;
            len_left <= len;
            cnt      <= '0;
            rx       <= '0;
          end else begin
            done <= 1'b1;
          end
        end
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (rise) begin
          sck <= 1'b1;
          cnt <= cnt + 1'b1;
        end
        if (fall) begin
          sck <= 1'b0;
          if (state == CMD || state == ADDR)
            tx <= tx << 1;
          if (state_d != state) cnt <= '0;
        end
        if (state == DATA && rise) begin
          rx <= rx_nxt[6:0];
          if (byte_end) begin
            cnt      <= '0;
            rd_data  <= rx_nxt;
            rd_valid <= 1'b1;
            len_left <= len_left - 1'b1;
          end
        end
        if (state == HOLD && tick) done <= 1'b1;
      end
    end
  end

endmodule

// File: doc/qspi_flash_ctrl.md
# qspi_flash_ctrl

Host-side QSPI read controller, the parametrised successor to the single-lane flash interface. It drives `cs_n`, `sck` and the four `io` lanes of a `qspi_flash_device`-class part from a system clock. It issues single (0x03), dual-output (0x3B) or quad-output (0x6B) read commands with configurable address width, dummy cycles and SCK divider. Read bytes stream out on a valid strobe; a done pulse closes each transaction.

## Interface
- `ADDR_W`, 24, address bits sent after the command (8..32)
- `LEN_W`, 8, width of byte-count input
- `CLK_DIV`, 2, clk cycles per SCK half-period (>=1)
- `DUMMY_CYC`, 8, SCK cycles between address and data for dual/quad modes
- `clk  in  1  system clock; all state changes on rising edge`
- `rst_n  in  1  asynchronous active-low reset`
- `start  in  1  request; sampled only while busy=0`
- `mode  in  2  00 single, 01 dual, 10 quad, 11 treated as single`
- `addr  in  ADDR_W  start byte address, captured with start`
- `len  in  LEN_W  bytes to read, captured with start`
- `busy  out  1  high from cycle after accepted start until done`
- `rd_data  out  8  last assembled byte, held until next`
- `rd_valid  out  1  one-cycle strobe per byte`
- `done  out  1  one-cycle pulse at transaction end`
- `cs_n  out  1  flash chip select, active low`
- `sck  out  1  flash clock, SPI mode 0 (idle low)`
- `io_out  out  4  lane drive values`
- `io_oe  out  4  per-lane output enable (1 = drive)`
- `io_in  in  4  lane sample values`

## Operation
- States: IDLE -> CMD -> ADDR -> DUMMY -> DATA -> HOLD -> IDLE.
- IDLE: start=1 with len!=0 captures mode/addr/len, sets busy, drops cs_n the next cycle. start with len=0: no bus activity, done pulses the next cycle, busy stays 0.
- Command byte: 0x03 / 0x3B / 0x6B by mode; mode 11 sends 0x03 and reads single. The command goes out on io[0], MSB first, 8 SCK cycles, io_oe=4'b0001.
- ADDR: ADDR_W bits on io[0], MSB first, io_oe=4'b0001.
- DUMMY: dual/quad only, DUMMY_CYC SCK cycles, io_oe=0. Single mode skips DUMMY.
- DATA: io_oe=0. Bits per SCK are 1 (io[1]), 2 ({io[1],io[0]}), or 4 (io[3:0]), higher lane = more significant bit. Bytes assemble MSB first. The byte is complete after 8, 4 or 2 SCK cycles respectively. Then rd_data updates and rd_valid pulses for 1 clk, len times.
- HOLD: sck low, cs_n high for CLK_DIV clk cycles (minimum deselect). Then done=1 for one cycle, busy=0 in that same cycle, and the state returns to IDLE. start is accepted from the following cycle.
- Total SCK rising edges = 8 + ADDR_W + (dual/quad ? DUMMY_CYC : 0) + len*8/lanes.
- Address is not auto-incremented by the controller; the flash increments internally.

## Timing
- Reset (async, immediate): cs_n=1, sck=0, io_out=0, io_oe=0, busy=0, rd_data=0x00, rd_valid=0, done=0, state IDLE. Asserting reset mid-transaction aborts immediately with no done and no rd_valid. The first start after release is accepted normally.
- Accept cycle T: busy=1 and cs_n=0 at T+1. io_out[0] carries the command MSB from T+1.
- SCK: low for CLK_DIV clk, then high for CLK_DIV clk. The first rising edge is at T+1+CLK_DIV.
- io_out changes only while sck is low, one CLK_DIV period before each rising edge. io_in is sampled on the clk where sck goes 0->1.
- Lane turnaround: io_oe drops to 0 in the same cycle sck falls after the last address bit.
- rd_valid asserts the cycle after the final sampling edge of each byte.
- After the last data rising edge, sck stays high for CLK_DIV, then falls. cs_n rises CLK_DIV later, then HOLD runs.
- start while busy=1 is ignored, with no effect on captured fields.

## Test plan
- Single read, CLK_DIV=2, addr=0x000000, len=2, model returns 0xA5,0x3C -> io[0] shows 0x03 then 24 zeros. rd_valid fires twice with 0xA5, 0x3C. 48 SCK rising edges; done once.
- Quad read, addr=0x123456, len=4, DUMMY_CYC=8, model returns 0x01,0x23,0x45,0x67 -> command 0x6B, 8 dummy edges with io_oe=0, 48 SCK edges total, bytes in order, one done.
- Dual read, CLK_DIV=1, len=1, model returns 0x9C -> command 0x3B, 44 SCK edges, rd_data=0x9C.
- len=0 and mode=11: len=0 -> cs_n stays 1, done pulses at T+1. mode=11 with len=1 -> command 0x03 and single-lane data.
- start pulsed mid-transaction with a different addr -> ignored; the captured address on io[0] is unchanged.
- rst_n low during DATA -> cs_n=1, sck=0 and io_oe=0 the same instant, no done. A new single read after release completes correctly.
